// File: rtl/i2c_codec_slave_if.sv
// i2c_codec_slave_if: I2C bus pins plus the decoded register-write port of the codec stand-in
interface i2c_codec_slave_if;
  logic       sclk;
  logic       sdat_i;
  logic       sdat_oe;
  logic       wr_valid;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [7:0] wr_count;
  logic       busy;
  modport master (output sclk, sdat_i, input sdat_oe, wr_valid, reg_addr, reg_data, wr_count, busy);
  modport slave  (input sclk, sdat_i, output sdat_oe, wr_valid, reg_addr, reg_data, wr_count, busy);
endinterface

// File: rtl/i2c_codec_slave.sv
// i2c_codec_slave: oversampled write-only I2C target decoding {addr7,d8},{d7..0} register frames
module i2c_codec_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input logic clk,
  input logic rst,
  i2c_codec_slave_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, A_ACK, HI, H_ACK, LO, L_ACK, IGNORE} state_t;
  state_t state, state_nx;
  logic [1:0] sclk_q, sdat_q;
  logic       p_sclk, p_sdat;
  logic [2:0] bit_cnt, bit_nx;
  logic [6:0] shreg, sh_nx, addr_l, addr_l_nx, addr, addr_nx;
  logic       d8, d8_nx, oe, oe_nx, vld, vld_nx, busy, busy_nx;
  logic [8:0] data, data_nx;
  logic [7:0] cnt, cnt_nx, rx;
  logic       s_sclk, s_sdat, rise, fall, start, stop, last, match;
  assign s_sclk = sclk_q[1];
  assign s_sdat = sdat_q[1];
  assign rise   = s_sclk & ~p_sclk;
  assign fall   = ~s_sclk & p_sclk;
  assign start  = s_sclk & p_sdat & ~s_sdat;
  assign stop   = s_sclk & ~p_sdat & s_sdat;
  assign rx     = {shreg, s_sdat};
  assign last   = bit_cnt == 3'd7;
  assign match  = rx == {DEV_ADDR, 1'b0};
  // Synchronizers preset to an idle (high) bus so reset never fakes a START
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sclk_q <= 2'b11;
      sdat_q <= 2'b11;
      p_sclk <= 1'b1;
      p_sdat <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[0], bus.sclk};
      sdat_q <= {sdat_q[0], bus.sdat_i};
      p_sclk <= s_sclk;
      p_sdat <= s_sdat;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      addr_l  <= '0;
      d8      <= 1'b0;
      addr    <= '0;
      data    <= '0;
      cnt     <= '0;
      oe      <= 1'b0;
      vld     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      shreg   <= sh_nx;
      addr_l  <= addr_l_nx;
      d8      <= d8_nx;
      addr    <= addr_nx;
      data    <= data_nx;
      cnt     <= cnt_nx;
      oe      <= oe_nx;
      vld     <= vld_nx;
      busy    <= busy_nx;
    end
  always_comb begin
    state_nx  = state;
    bit_nx    = bit_cnt;
    sh_nx     = shreg;
    addr_l_nx = addr_l;
    d8_nx     = d8;
    addr_nx   = addr;
    data_nx   = data;
    cnt_nx    = cnt;
    oe_nx     = oe;
    vld_nx    = 1'b0;
    busy_nx   = busy;
    if (start || stop) begin
      state_nx = start ? ADDR : IDLE;
      bit_nx   = '0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else if (rise && (state == ADDR || state == HI || state == LO)) begin
      sh_nx  = rx[6:0];
      bit_nx = bit_cnt + 3'd1;
      if (last && state == ADDR) begin
        state_nx = match ? A_ACK : IGNORE;
        busy_nx  = match;
      end else if (last && state == HI) begin
        state_nx  = H_ACK;
        addr_l_nx = rx[7:1];
        d8_nx     = rx[0];
      end else if (last) begin
        state_nx = L_ACK;
        addr_nx  = addr_l;
        data_nx  = {d8, rx};
        vld_nx   = 1'b1;
        cnt_nx   = cnt + 8'd1;
      end
    end else if (fall && (state == A_ACK || state == H_ACK || state == L_ACK)) begin
      // First falling edge opens the ACK slot, the second closes it and moves on
      oe_nx    = ~oe;
      state_nx = oe ? (state == H_ACK ? LO : HI) : state;
    end
  end
  assign bus.sdat_oe  = oe;
  assign bus.wr_valid = vld;
  assign bus.reg_addr = addr;
  assign bus.reg_data = data;
  assign bus.wr_count = cnt;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_i2c_codec_slave.sv
// tb_i2c_codec_slave: bit-banged I2C master with a frame-level reference model of the codec port
module tb_i2c_codec_slave;
  localparam int Q = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_sdat = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int vld_cyc = 0;
  int exp_cnt = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0] tx[$];
  i2c_codec_slave_if bus();
  assign bus.sdat_i = m_sdat & ~bus.sdat_oe;
  i2c_codec_slave dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.wr_valid === 1'b1) begin
      got_q.push_back({bus.reg_addr, bus.reg_data});
      vld_cyc = cyc;
    end
  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sdat = 1'b1;
    bus.sclk = 1'b1;
    wq(Q);
    m_sdat = 1'b0;
    wq(Q);
    bus.sclk = 1'b0;
    wq(Q);
  endtask
  task automatic i2c_stop;
    m_sdat = 1'b0;
    wq(Q);
    bus.sclk = 1'b1;
    wq(Q);
    m_sdat = 1'b1;
    wq(Q);
  endtask
  task automatic send_bits(input logic [7:0] b, output logic oe_seen);
    oe_seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_sdat = b[i];
      wq(Q);
      bus.sclk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      wq(Q);
      oe_seen = oe_seen | bus.sdat_oe;
      wq(Q);
      bus.sclk = 1'b0;
      wq(Q);
    end
  endtask
  task automatic ack_clk(output logic oe_mid);
    m_sdat = 1'b1;
    wq(Q);
    bus.sclk = 1'b1;
    wq(Q);
    oe_mid = bus.sdat_oe;
    wq(Q);
    bus.sclk = 1'b0;
    wq(Q);
  endtask
  task automatic send_txn(input bit do_stop);
    logic oe_d, oe_a;
    bit match;
    match = tx[0] == 8'h34;
    i2c_start();
    for (int i = 0; i < tx.size(); i++) begin
      send_bits(tx[i], oe_d);
      total++;
      if (oe_d !== 1'b0) begin
        bad++;
        $display("FAIL oe_data byte %0d: sdat_oe=%0b want 0", i, oe_d);
      end
      ack_clk(oe_a);
      total++;
      if (oe_a !== match) begin
        bad++;
        $display("FAIL ack byte %0d (0x%02h): sdat_oe=%0b want %0b", i, tx[i], oe_a, match);
      end
      if (i == 0) begin
        total++;
        if (bus.busy !== match) begin
          bad++;
          $display("FAIL busy_after_addr: busy=%0b want %0b", bus.busy, match);
        end
      end
    end
    if (do_stop) i2c_stop();
    if (match)
      for (int k = 1; k + 1 < tx.size(); k += 2) begin
        exp_q.push_back({tx[k][7:1], tx[k][0], tx[k+1]});
        exp_cnt = (exp_cnt + 1) % 256;
      end
  endtask
  task automatic check_frames(input string name);
    wq(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s frame count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s frame %0d: addr/data=%02h/%03h want %02h/%03h", name, i,
                   got_q[i][15:9], got_q[i][8:0], exp_q[i][15:9], exp_q[i][8:0]);
        end
      end
    total++;
    if (bus.wr_count !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL %s wr_count: got %0d want %0d", name, bus.wr_count, exp_cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic check_idle(input string name);
    total++;
    if (bus.busy !== 1'b0 || bus.sdat_oe !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: busy=%0b sdat_oe=%0b want 0/0", name, bus.busy, bus.sdat_oe);
    end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    wq(3);
    total += 6;
    if (bus.sdat_oe !== 1'b0) begin bad++; $display("FAIL reset sdat_oe: got %0b want 0", bus.sdat_oe); end
    if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset wr_valid: got %0b want 0", bus.wr_valid); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %0b want 0", bus.busy); end
    if (bus.wr_count !== 8'd0) begin bad++; $display("FAIL reset wr_count: got %0d want 0", bus.wr_count); end
    if (bus.reg_addr !== 7'd0) begin bad++; $display("FAIL reset reg_addr: got %0h want 0", bus.reg_addr); end
    if (bus.reg_data !== 9'd0) begin bad++; $display("FAIL reset reg_data: got %0h want 0", bus.reg_data); end
    rst = 1'b1;
    wq(2);
  endtask
  task automatic test_single;
    tx = '{8'h34, 8'h00, 8'h97};
    send_txn(1);
    total++;
    if (vld_cyc - rise_cyc != 3) begin
      bad++;
      $display("FAIL latency: got %0d clks want 3", vld_cyc - rise_cyc);
    end
    total++;
    if (bus.reg_addr !== 7'h00 || bus.reg_data !== 9'h097) begin
      bad++;
      $display("FAIL single regs: %02h/%03h want 00/097", bus.reg_addr, bus.reg_data);
    end
    check_frames("single");
    check_idle("single");
  endtask
  task automatic test_codec_init;
    tx = '{8'h34, 8'h00, 8'h97, 8'h02, 8'h97, 8'h04, 8'h79, 8'h06, 8'h79, 8'h08, 8'h12,
           8'h0A, 8'h06, 8'h0C, 8'h00, 8'h0E, 8'h01, 8'h10, 8'h02, 8'h12, 8'h01, 8'h1E, 8'h00};
    send_txn(1);
    total++;
    if (bus.reg_addr !== 7'h0F || bus.reg_data !== 9'h000) begin
      bad++;
      $display("FAIL init last regs: %02h/%03h want 0f/000", bus.reg_addr, bus.reg_data);
    end
    check_frames("init");
    check_idle("init");
  endtask
  task automatic test_wrong_addr;
    tx = '{8'h36, 8'h00, 8'h97};
    send_txn(1);
    check_frames("wrong_addr");
    tx = '{8'h35, 8'h00, 8'h97};
    send_txn(1);
    check_frames("read_addr");
    check_idle("wrong_addr");
  endtask
  task automatic test_partial;
    tx = '{8'h34, 8'h08};
    send_txn(0);
    tx = '{8'h34, 8'h12, 8'h01};
    send_txn(1);
    check_frames("partial");
    check_idle("partial");
  endtask
  task automatic test_reset_mid;
    logic oe_d, oe_a;
    i2c_start();
    send_bits(8'h34, oe_d);
    ack_clk(oe_a);
    send_bits(8'h08, oe_d);
    total++;
    if (bus.sdat_oe !== 1'b1) begin
      bad++;
      $display("FAIL h_ack before reset: sdat_oe=%0b want 1", bus.sdat_oe);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.sdat_oe !== 1'b0) begin
      bad++;
      $display("FAIL async reset sdat_oe: got %0b want 0", bus.sdat_oe);
    end
    wq(2);
    i2c_stop();
    rst = 1'b1;
    wq(2);
    exp_cnt = 0;
    got_q.delete();
    exp_q.delete();
    tx = '{8'h34, 8'h00, 8'h97};
    send_txn(1);
    check_frames("after_reset");
  endtask
  task automatic test_random;
    int r, nb;
    bit st;
    for (int t = 0; t < 16; t++) begin
      tx.delete();
      r = $urandom_range(0, 3);
      tx.push_back(r < 2 ? 8'h34 : r == 2 ? ($urandom_range(0, 1) ? 8'h36 : 8'h35) : 8'($urandom));
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) tx.push_back(8'($urandom));
      st = (t == 15) || ($urandom_range(0, 3) != 0);
      send_txn(st);
      check_frames("random");
    end
    check_idle("random");
  endtask
  initial begin
    bus.sclk = 1'b1;
    test_reset();
    test_single();
    test_codec_init();
    test_wrong_addr();
    test_partial();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
